demux1to8_deser: RTL and testbench
==================================

// Module: demux1to8_deser
// PURPOSE
//  Receive-side counterpart of the 8:1 mux serializer path. Takes a serial bit stream,
//  routes each bit to the output position named by an internal 3-bit select counter
//  (1:8 demux), and presents each completed 8-bit word on a valid/ready output port.
//  Sits between the serial link and the word-level consumer.
// PARAMETERS
//  WIDTH   8                  word width; bits per frame
//  SEL_W   $clog2(WIDTH) = 3  select counter width
// PORTS
//  clk          in   1      single clock; all state changes on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_bit       in   1      serial data bit
//  in_valid     in   1      in_bit valid this cycle
//  frame_start  in   1      qualified by in_valid; marks bit 0 of a frame
//  out_word     out  WIDTH  assembled word; stable while out_valid=1
//  out_valid    out  1      word available
//  out_ready    in   1      consumer accepts word when out_valid&&out_ready
//  sel          out  SEL_W  current demux select (position of next bit)
//  busy         out  1      frame in progress (state != IDLE)
//  overflow     out  1      sticky: completed word dropped
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, sel=0, shadow=0, out_word=0, out_valid=0,
//   busy=0, overflow=0 (also perr=0 if enabled).
//  Bit order: frame bit k goes to out_word[k] (LSB first), k = sel at that beat.
//  FSM: IDLE -> SHIFT on in_valid&&frame_start (bit captured to shadow[0], sel<=1).
//   SHIFT: each in_valid beat writes shadow[sel], sel<=sel+1. Cycles without
//   in_valid hold all state. Beat at sel==WIDTH-1 completes word: sel<=0, state<=IDLE.
//   in_valid&&frame_start in SHIFT: partial word discarded, beat taken as new bit 0.
//   in_valid without frame_start in IDLE: bit ignored.
//  Word commit (completion cycle, or PARITY beat if enabled): out_word<=assembled
//   word, out_valid<=1 next cycle; latency = 1 cycle after last data bit.
//  Output handshake: out_valid held, out_word stable, until out_valid&&out_ready.
//   Commit while out_valid&&!out_ready: new word dropped, overflow<=1 (sticky to reset).
//   Commit in same cycle as accept: new word loaded, out_valid stays 1, no overflow.
//   Accept with no commit: out_valid<=0.
//  sel wraps WIDTH-1 -> 0 only at word completion; never counts past WIDTH-1.
// CONFIGURATION
//  PARITY_CHECK_EN defined: frame is WIDTH data bits + 1 even-parity bit. After bit
//   WIDTH-1 FSM enters PARITY; next in_valid beat is parity. Extra output perr (1b):
//   updated with every committed word, 1 when XOR(data,parity)=1; word still
//   delivered. frame_start on the parity beat = restart (word discarded).
//  Undefined: no PARITY state, no perr port; frame = WIDTH bits exactly.
// STRUCTURE
//  Package demux_pkg: state enum {IDLE, SHIFT, PARITY}, DEMUX_WIDTH_DEF=8.
//  Sub-module demux_sel_counter: SEL_W counter with clear, enable, terminal flag
//   (sel==WIDTH-1); top holds FSM, shadow reg, output register/handshake.
// TESTING
//  1 Reset mid-frame (after 3 bits) -> all outputs 0 immediately, sel=0.
//  2 Bits 1,0,1,0,1,0,1,0 (first with frame_start), out_ready=1 -> out_word=8'h55,
//    out_valid=1 for one cycle, one cycle after last bit.
//  3 Frame 8'hA5 with in_valid gaps of 2 cycles between bits -> out_word=8'hA5.
//  4 out_ready=0, send 8'h0F then 8'hF0 -> out_word stays 8'h0F, overflow=1;
//    raise out_ready -> 8'h0F accepted, out_valid=0.
//  5 frame_start at bit 4, then full 8'h3C -> out_word=8'h3C, no partial word.
//  6 PARITY_CHECK_EN: 8'h81 + parity 0 -> perr=0; 8'h81 + parity 1 -> perr=1.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and defaults for the 1:8 demux deserializer.
// Optional feature macro: PARITY_CHECK_EN (adds the PARITY state).
package demux_pkg;

    localparam int DEMUX_WIDTH_DEF = 8;

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/demux_sel_counter.sv
// Demux select counter: position of the next serial bit within the word.
// clr restarts the count at 0; with en also set, the current beat is taken
// as position 0, so sel lands on 1. sel wraps WIDTH-1 -> 0 on an enabled beat.
module demux_sel_counter #(
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] sel,
    output logic             term
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] sel_next;

    assign term = (sel == LAST);

    // Next select value from clear/enable.
    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        base     = clr ? '0 : sel;
        sel_next = base;
        if (en) begin
            sel_next = (base == LAST) ? '0 : base + 1'b1;
        end
    end

    // Select register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= '0;
        end else begin
            sel <= sel_next;
        end
    end

endmodule

// File: rtl/demux1to8_deser.sv
// 1:8 demux deserializer: routes serial bits (LSB first) into a shadow word
// and presents each completed word on a valid/ready output port.
// Optional feature macro: PARITY_CHECK_EN (even-parity beat after the data
// bits, extra perr output).
module demux1to8_deser
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
`ifdef PARITY_CHECK_EN
    output logic             perr,
`endif
    output logic             overflow
);

    state_t           state, state_next;
    logic [WIDTH-1:0] shadow, shadow_next;
    logic [WIDTH-1:0] beat_word;
    logic [WIDTH-1:0] restart_word;
    logic [WIDTH-1:0] commit_word;
    logic             commit;
    logic             cnt_clr, cnt_en;
    logic             sel_term;
`ifdef PARITY_CHECK_EN
    logic             commit_perr;
`endif

    demux_sel_counter #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_sel_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .sel   (sel),
        .term  (sel_term)
    );

    assign busy = (state != IDLE);

    // Frame FSM next state, shadow update and word-commit decision.
    always_comb begin
        state_next   = state;
        shadow_next  = shadow;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        commit       = 1'b0;
        beat_word    = shadow;
        beat_word[sel] = in_bit;
        restart_word = {{(WIDTH-1){1'b0}}, in_bit};
        commit_word  = beat_word;
`ifdef PARITY_CHECK_EN
        commit_perr  = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Bits outside a frame are ignored until a frame_start beat.
                if (in_valid && frame_start) begin
                    state_next  = SHIFT;
                    shadow_next = restart_word;
                    cnt_clr     = 1'b1;
                    cnt_en      = 1'b1;
                end
            end
            SHIFT: begin
                if (in_valid) begin
                    cnt_en = 1'b1;
                    if (frame_start) begin
                        // Partial word dropped; this beat is the new bit 0.
                        shadow_next = restart_word;
                        cnt_clr     = 1'b1;
                    end else begin
                        shadow_next = beat_word;
                        if (sel_term) begin
`ifdef PARITY_CHECK_EN
                            state_next = PARITY;
`else
                            state_next = IDLE;
                            commit     = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                if (in_valid) begin
                    if (frame_start) begin
                        state_next  = SHIFT;
                        shadow_next = restart_word;
                        cnt_clr     = 1'b1;
                        cnt_en      = 1'b1;
                    end else begin
                        state_next  = IDLE;
                        commit      = 1'b1;
                        commit_word = shadow;
                        commit_perr = ^{shadow, in_bit};
                    end
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and shadow registers.
    // NOTE: the shadow word is a plain register, not a memory, so it is reset like any other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
        end else begin
            state  <= state_next;
            shadow <= shadow_next;
        end
    end

    // Output register with valid/ready handshake and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr      <= 1'b0;
`endif
        end else if (commit) begin
            if (!out_valid || out_ready) begin
                out_word  <= commit_word;
                out_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
                perr      <= commit_perr;
`endif
            end else begin
                overflow <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux1to8_deser.sv
// Directed self-checking bench for demux1to8_deser.
// Optional feature macro: PARITY_CHECK_EN (must match the RTL build).
module tb_demux1to8_deser;

    localparam int WIDTH = 8;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_bit;
    logic             in_valid;
    logic             frame_start;
    logic [WIDTH-1:0] out_word;
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             overflow;
`ifdef PARITY_CHECK_EN
    logic             perr;
`endif

    int checks = 0;
    int errors = 0;

    demux1to8_deser #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .out_word    (out_word),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sel         (sel),
        .busy        (busy),
`ifdef PARITY_CHECK_EN
        .perr        (perr),
`endif
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One in_valid beat, driven from a falling edge; returns on the next falling edge.
    task automatic beat(input logic b, input logic fs);
        in_valid    = 1'b1;
        in_bit      = b;
        frame_start = fs;
        @(negedge clk);
        in_valid    = 1'b0;
        frame_start = 1'b0;
        in_bit      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full frame, LSB first, with 'gap' idle cycles between beats and a correct parity beat when enabled.
    task automatic send_word(input logic [WIDTH-1:0] w, input int gap);
        for (int k = 0; k < WIDTH; k++) begin
            beat(w[k], k == 0);
            if (k != WIDTH - 1) idle(gap);
        end
`ifdef PARITY_CHECK_EN
        beat(^w, 1'b0);
`endif
    endtask

    // Closing beat(s) after bits 0..WIDTH-2 were sent; accept_last raises out_ready on the commit beat.
    task automatic finish_word(input logic [WIDTH-1:0] w, input logic accept_last);
`ifdef PARITY_CHECK_EN
        beat(w[WIDTH-1], 1'b0);
        if (accept_last) out_ready = 1'b1;
        beat(^w, 1'b0);
`else
        if (accept_last) out_ready = 1'b1;
        beat(w[WIDTH-1], 1'b0);
`endif
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        rst_n       = 1'b0;
        in_bit      = 1'b0;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b1;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word", 32'(out_word), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: reset mid-frame after three bits
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        check("t1_sel_before", 32'(sel), 32'd3);
        check("t1_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t1_sel_rst", 32'(sel), 32'd0);
        check("t1_busy_rst", 32'(busy), 32'd0);
        check("t1_valid_rst", 32'(out_valid), 32'd0);
        check("t1_word_rst", 32'(out_word), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2: 8'h55 back-to-back, one-cycle latency, single-cycle valid
        w = 8'h55;
        for (int k = 0; k < WIDTH - 1; k++) beat(w[k], k == 0);
        check("t2_sel_last", 32'(sel), 32'd7);
        check("t2_valid_early", 32'(out_valid), 32'd0);
        finish_word(w, 1'b0);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_word", 32'(out_word), 32'h55);
        check("t2_sel_wrap", 32'(sel), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);
`ifdef PARITY_CHECK_EN
        check("t2_perr", 32'(perr), 32'd0);
`endif
        @(negedge clk);
        check("t2_valid_drop", 32'(out_valid), 32'd0);

        // 3: 8'hA5 with two idle cycles between beats
        w = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            beat(w[k], k == 0);
            idle(2);
        end
        check("t3_sel_hold", 32'(sel), 32'd4);
        check("t3_busy_hold", 32'(busy), 32'd1);
        for (int k = 4; k < WIDTH - 1; k++) begin
            beat(w[k], 1'b0);
            idle(2);
        end
        finish_word(w, 1'b0);
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_word", 32'(out_word), 32'hA5);
        @(negedge clk);

        // 4: consumer stalled, second word dropped, sticky overflow
        out_ready = 1'b0;
        send_word(8'h0F, 0);
        check("t4_valid1", 32'(out_valid), 32'd1);
        check("t4_word1", 32'(out_word), 32'h0F);
        check("t4_ovf_clear", 32'(overflow), 32'd0);
        send_word(8'hF0, 0);
        check("t4_word_kept", 32'(out_word), 32'h0F);
        check("t4_valid_kept", 32'(out_valid), 32'd1);
        check("t4_ovf_set", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_accept", 32'(out_valid), 32'd0);
        idle(3);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t4_ovf_rst", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 5: restart at bit 4, then full 8'h3C; stray bit in IDLE ignored
        beat(1'b1, 1'b0);
        check("t5_idle_sel", 32'(sel), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) beat(1'b1, k == 0);
        check("t5_sel_pre", 32'(sel), 32'd4);
        w = 8'h3C;
        beat(w[0], 1'b1);
        check("t5_sel_restart", 32'(sel), 32'd1);
        for (int k = 1; k < WIDTH - 1; k++) beat(w[k], 1'b0);
        check("t5_no_partial", 32'(out_valid), 32'd0);
        finish_word(w, 1'b0);
        check("t5_valid", 32'(out_valid), 32'd1);
        check("t5_word", 32'(out_word), 32'h3C);
        @(negedge clk);

        // Commit in the same cycle as accept: new word loads, no overflow
        out_ready = 1'b0;
        send_word(8'h12, 0);
        check("tc_valid1", 32'(out_valid), 32'd1);
        w = 8'h34;
        for (int k = 0; k < WIDTH - 1; k++) beat(w[k], k == 0);
        check("tc_word_held", 32'(out_word), 32'h12);
        finish_word(w, 1'b1);
        check("tc_word_new", 32'(out_word), 32'h34);
        check("tc_valid_kept", 32'(out_valid), 32'd1);
        check("tc_no_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        check("tc_drained", 32'(out_valid), 32'd0);

`ifdef PARITY_CHECK_EN
        // 6: parity good / bad; word delivered either way
        w = 8'h81;
        for (int k = 0; k < WIDTH; k++) beat(w[k], k == 0);
        check("t6_busy_par", 32'(busy), 32'd1);
        check("t6_valid_wait", 32'(out_valid), 32'd0);
        beat(1'b0, 1'b0);
        check("t6_word_ok", 32'(out_word), 32'h81);
        check("t6_perr0", 32'(perr), 32'd0);
        @(negedge clk);
        for (int k = 0; k < WIDTH; k++) beat(w[k], k == 0);
        beat(1'b1, 1'b0);
        check("t6_word_bad", 32'(out_word), 32'h81);
        check("t6_valid_bad", 32'(out_valid), 32'd1);
        check("t6_perr1", 32'(perr), 32'd1);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
